// File: rtl/cim_pkg.sv
// Shared state encodings and width helpers for the CIM sequencer.
package cim_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_ACT = 3'd1;
    localparam logic [2:0] ST_LOAD_Q   = 3'd2;
    localparam logic [2:0] ST_STREAM   = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_RESULT   = 3'd5;

    function automatic int unsigned stage4_out_width(input int unsigned in_w,
                                                     input int unsigned num_in,
                                                     input int unsigned scale_w);
        return in_w + $clog2(num_in) + scale_w;
    endfunction

endpackage

// File: rtl/cim_beat_counter.sv
// Load/decrement counter with a terminal flag raised while the count is one.
module cim_beat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Saturates at zero so a stray decrement can never wrap mid-job.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/cim_sequencer.sv
// Job sequencer for one CIM stacked datapath: loads activations and scale queue,
// streams weight beats, drains the pipeline and hands back each pass result.
module cim_sequencer
    import cim_pkg::*;
#(
    parameter int unsigned NUM_STACKS            = 8,
    parameter int unsigned STAGE_1_NUM_INPUTS    = 8,
    parameter int unsigned STAGE_1_BIT_WIDTH     = 8,
    parameter int unsigned STAGE_4_BIT_WIDTH     = 4,
    parameter int unsigned QUEUE_DEPTH           = 4,
    parameter int unsigned PIPE_LATENCY          = 4,
    parameter int unsigned STAGE_4_OUT_BIT_WIDTH =
        stage4_out_width(STAGE_1_BIT_WIDTH, STAGE_1_NUM_INPUTS, STAGE_4_BIT_WIDTH)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [7:0]                                  cmd_num_passes,
    input  logic                                        abort,
    input  logic [NUM_STACKS*STAGE_1_BIT_WIDTH-1:0]     act_data,
    input  logic                                        scale_valid,
    output logic                                        scale_ready,
    input  logic [STAGE_4_BIT_WIDTH-1:0]                scale_data,
    input  logic                                        wt_valid,
    output logic                                        wt_ready,
    input  logic [NUM_STACKS*STAGE_1_BIT_WIDTH-1:0]     wt_data,
    output logic                                        wrEn_act_array,
    output logic [NUM_STACKS*STAGE_1_BIT_WIDTH-1:0]     wrData_act,
    output logic                                        wrEn_queue,
    output logic [STAGE_4_BIT_WIDTH-1:0]                wrData_queue,
    output logic [NUM_STACKS*STAGE_1_BIT_WIDTH-1:0]     input_wt,
    output logic                                        SRAM_flop_en_in,
    output logic                                        flop_1_en_in,
    output logic                                        flop_3_en_in,
    output logic                                        queue_en_in,
    input  logic [NUM_STACKS*STAGE_4_OUT_BIT_WIDTH-1:0] stage_4_out,
    output logic                                        res_valid,
    input  logic                                        res_ready,
    output logic [NUM_STACKS*STAGE_4_OUT_BIT_WIDTH-1:0] res_data,
    output logic                                        busy,
    output logic                                        done
);

    localparam int unsigned VEC_W = NUM_STACKS * STAGE_1_BIT_WIDTH;
    localparam int unsigned RES_W = NUM_STACKS * STAGE_4_OUT_BIT_WIDTH;
    localparam int unsigned Q_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned B_W   = $clog2(STAGE_1_NUM_INPUTS + 1);
    localparam int unsigned L_W   = $clog2(PIPE_LATENCY + 1);
    localparam int unsigned P_W   = 8;

    logic [2:0]       state_q, state_d;
    logic [VEC_W-1:0] act_q, act_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             done_q, done_d;

    logic st_idle, st_load_act, st_load_q, st_stream, st_drain, st_result;
    logic cmd_hs, scale_hs, wt_hs, res_hs, pipe_en;
    logic q_load, q_dec, q_last;
    logic beat_load, beat_dec, beat_last;
    logic lat_load, lat_dec, lat_last;
    logic pass_load, pass_dec, pass_last;

    assign st_idle     = (state_q == ST_IDLE);
    assign st_load_act = (state_q == ST_LOAD_ACT);
    assign st_load_q   = (state_q == ST_LOAD_Q);
    assign st_stream   = (state_q == ST_STREAM);
    assign st_drain    = (state_q == ST_DRAIN);
    assign st_result   = (state_q == ST_RESULT);

    // Readies are masked by abort so abort wins over any same-cycle handshake.
    assign cmd_ready   = st_idle   & ~abort;
    assign scale_ready = st_load_q & ~abort;
    assign wt_ready    = st_stream & ~abort;
    assign res_valid   = st_result & ~abort;

    assign cmd_hs   = cmd_valid   & cmd_ready;
    assign scale_hs = scale_valid & scale_ready;
    assign wt_hs    = wt_valid    & wt_ready;
    assign res_hs   = res_valid   & res_ready;
    assign pipe_en  = wt_hs | (st_drain & ~abort);

    assign wrEn_act_array  = st_load_act & ~abort;
    assign wrData_act      = act_q;
    assign wrEn_queue      = scale_hs;
    assign wrData_queue    = scale_hs ? scale_data : '0;
    assign input_wt        = wt_hs ? wt_data : '0;
    assign SRAM_flop_en_in = pipe_en;
    assign flop_1_en_in    = pipe_en;
    assign flop_3_en_in    = pipe_en;
    assign queue_en_in     = pipe_en;
    assign res_data        = res_q;
    assign busy            = ~st_idle;
    assign done            = done_q;

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        res_d     = res_q;
        done_d    = 1'b0;
        q_load    = 1'b0;
        q_dec     = 1'b0;
        beat_load = 1'b0;
        beat_dec  = 1'b0;
        lat_load  = 1'b0;
        lat_dec   = 1'b0;
        pass_load = 1'b0;
        pass_dec  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        act_d = act_data;
                        if (cmd_num_passes == 8'd0) begin
                            done_d = 1'b1;
                        end else begin
                            pass_load = 1'b1;
                            state_d   = ST_LOAD_ACT;
                        end
                    end
                end
                ST_LOAD_ACT: begin
                    q_load  = 1'b1;
                    state_d = ST_LOAD_Q;
                end
                ST_LOAD_Q: begin
                    if (scale_hs) begin
                        q_dec = 1'b1;
                        if (q_last) begin
                            beat_load = 1'b1;
                            state_d   = ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (wt_hs) begin
                        beat_dec = 1'b1;
                        if (beat_last) begin
                            lat_load = 1'b1;
                            state_d  = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    lat_dec = 1'b1;
                    if (lat_last) begin
                        res_d   = stage_4_out;
                        state_d = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_hs) begin
                        pass_dec = 1'b1;
                        if (pass_last) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            beat_load = 1'b1;
                            state_d   = ST_STREAM;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    cim_beat_counter #(.WIDTH(Q_W)) u_q_cnt (
        .clk(clk), .rst_n(reset), .clr_i(abort), .load_i(q_load),
        .load_val_i(Q_W'(QUEUE_DEPTH)), .dec_i(q_dec), .last_o(q_last)
    );

    cim_beat_counter #(.WIDTH(B_W)) u_beat_cnt (
        .clk(clk), .rst_n(reset), .clr_i(abort), .load_i(beat_load),
        .load_val_i(B_W'(STAGE_1_NUM_INPUTS)), .dec_i(beat_dec), .last_o(beat_last)
    );

    cim_beat_counter #(.WIDTH(L_W)) u_lat_cnt (
        .clk(clk), .rst_n(reset), .clr_i(abort), .load_i(lat_load),
        .load_val_i(L_W'(PIPE_LATENCY)), .dec_i(lat_dec), .last_o(lat_last)
    );

    cim_beat_counter #(.WIDTH(P_W)) u_pass_cnt (
        .clk(clk), .rst_n(reset), .clr_i(abort), .load_i(pass_load),
        .load_val_i(cmd_num_passes), .dec_i(pass_dec), .last_o(pass_last)
    );

endmodule

// File: tb/tb_cim_sequencer.sv
// Directed bench for cim_sequencer: hand-derived timelines, counts and result values.
module tb_cim_sequencer;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, abort;
    logic [7:0]    cmd_num_passes;
    logic [63:0]   act_data, wt_data, wrData_act, input_wt;
    logic          scale_valid, scale_ready, wt_valid, wt_ready;
    logic [3:0]    scale_data, wrData_queue;
    logic          wrEn_act_array, wrEn_queue;
    logic          SRAM_flop_en_in, flop_1_en_in, flop_3_en_in, queue_en_in;
    logic [119:0]  stage_4_out, res_data;
    logic          res_valid, res_ready, busy, done;

    int tests = 0;
    int fails = 0;
    int n_act, n_q, n_wt, n_res, n_done, en_err, stab_err, wt_in_res, res_err;
    int first_res, last_hs, done_k;

    localparam logic [63:0] ACT_VEC = 64'h0102_0304_0506_0708;

    always #5 clk = ~clk;

    cim_sequencer #(
        .NUM_STACKS(8), .STAGE_1_NUM_INPUTS(8), .STAGE_1_BIT_WIDTH(8),
        .STAGE_4_BIT_WIDTH(4), .QUEUE_DEPTH(4), .PIPE_LATENCY(4)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_num_passes(cmd_num_passes), .abort(abort), .act_data(act_data),
        .scale_valid(scale_valid), .scale_ready(scale_ready), .scale_data(scale_data),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .wrEn_act_array(wrEn_act_array), .wrData_act(wrData_act),
        .wrEn_queue(wrEn_queue), .wrData_queue(wrData_queue), .input_wt(input_wt),
        .SRAM_flop_en_in(SRAM_flop_en_in), .flop_1_en_in(flop_1_en_in),
        .flop_3_en_in(flop_3_en_in), .queue_en_in(queue_en_in),
        .stage_4_out(stage_4_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [119:0] good_res(input int p);
        logic [119:0] r;
        for (int s = 0; s < 8; s++) r[s*15 +: 15] = 15'(15'h1234 + 16 * s + p);
        return r;
    endfunction

    task automatic quiet_inputs();
        cmd_valid = 1'b0; abort = 1'b0; scale_valid = 1'b0; wt_valid = 1'b0;
        res_ready = 1'b0; cmd_num_passes = 8'd0; act_data = '0; wt_data = '0;
        scale_data = '0; stage_4_out = '0;
    endtask

    // One job with cmd presented at k=0; pass-1 enables checked against the
    // hand timeline (LOAD_ACT k=1, LOAD_Q k=2..5, stream from k=6).
    task automatic run_job(input logic [7:0] passes, input bit toggle, input int hold);
        int  hold_left, p, stream_end;
        bit  in_res, exp_en;
        logic [119:0] held;
        n_act = 0; n_q = 0; n_wt = 0; n_res = 0; n_done = 0; en_err = 0;
        stab_err = 0; wt_in_res = 0; res_err = 0;
        first_res = -1; last_hs = -1; done_k = -1;
        hold_left = hold; p = 0; in_res = 1'b0; held = '0;
        stream_end = toggle ? 21 : 13;
        for (int k = 0; k < 600 && done_k < 0; k++) begin
            @(posedge clk); #2;
            cmd_valid      = (k == 0);
            cmd_num_passes = passes;
            act_data       = ACT_VEC;
            scale_valid    = 1'b1;
            scale_data     = 4'(k + 3);
            wt_valid       = toggle ? k[0] : 1'b1;
            wt_data        = {8{8'(k)}};
            stage_4_out    = in_res ? ~good_res(p) : good_res(p);
            res_ready      = (hold_left == 0);
            #1;
            if (wrEn_act_array) begin
                n_act++;
                if (wrData_act !== ACT_VEC) res_err++;
            end
            if (wrEn_queue) n_q++;
            if (wt_valid && wt_ready) n_wt++;
            if ({SRAM_flop_en_in, flop_3_en_in, queue_en_in} !== {3{flop_1_en_in}}) en_err++;
            if (p == 0) begin
                exp_en = (k >= 6 && k <= stream_end) ? wt_valid
                                                     : (k > stream_end && k <= stream_end + 4);
                if (flop_1_en_in !== exp_en) en_err++;
            end
            if (res_valid) begin
                if (first_res < 0) first_res = k;
                if (!in_res) begin
                    in_res = 1'b1;
                    held   = res_data;
                    if (res_data !== good_res(p)) res_err++;
                end else if (res_data !== held) begin
                    stab_err++;
                end
                if (wt_valid && wt_ready) wt_in_res++;
                if (hold_left > 0) hold_left--;
                if (res_ready) begin
                    n_res++; p++; in_res = 1'b0; last_hs = k;
                end
            end
            if (done) begin
                n_done++; done_k = k;
            end
        end
        @(posedge clk); #2;
        quiet_inputs();
        #1;
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst res_valid", res_valid, 0);
        chk("rst res_data", res_data, 0);
        chk("rst strobes", {wrEn_act_array, wrEn_queue, scale_ready, wt_ready}, 0);
        chk("rst enables", {SRAM_flop_en_in, flop_1_en_in, flop_3_en_in, queue_en_in}, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1 pass, everything ready
        run_job(8'd1, 1'b0, 0);
        chk("p1 finished", done_k >= 0, 1);
        chk("p1 latency", first_res - 1, 17);
        chk("p1 done gap", done_k - last_hs, 1);
        chk("p1 result", res_err, 0);
        chk("p1 counts", {8'(n_act), 8'(n_q), 8'(n_wt), 8'(n_res), 8'(n_done)},
            {8'd1, 8'd4, 8'd8, 8'd1, 8'd1});
        chk("p1 enables", en_err, 0);
        chk("p1 idle after", {busy, done, cmd_ready}, 3'b001);

        // 3 passes: one load, three stream/drain/result rounds
        run_job(8'd3, 1'b0, 0);
        chk("p3 finished", done_k >= 0, 1);
        chk("p3 latency", first_res - 1, 17);
        chk("p3 counts", {8'(n_act), 8'(n_q), 8'(n_wt), 8'(n_res), 8'(n_done)},
            {8'd1, 8'd4, 8'd24, 8'd3, 8'd1});
        chk("p3 results", res_err, 0);
        chk("p3 enables", en_err, 0);
        chk("p3 wt during result", wt_in_res, 0);

        // wt_valid toggling: 8 extra stream cycles
        run_job(8'd1, 1'b1, 0);
        chk("tog finished", done_k >= 0, 1);
        chk("tog latency", first_res - 1, 25);
        chk("tog enables", en_err, 0);
        chk("tog result", res_err, 0);
        chk("tog wt beats", n_wt, 8);

        // res_ready held low for 10 cycles
        run_job(8'd1, 1'b0, 10);
        chk("hold finished", done_k >= 0, 1);
        chk("hold length", last_hs - first_res, 10);
        chk("hold stable", stab_err, 0);
        chk("hold no wt", wt_in_res, 0);
        chk("hold result", res_err, 0);
        chk("hold done gap", done_k - last_hs, 1);

        // abort during LOAD_Q with a scale entry on offer
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_num_passes = 8'd2; act_data = ACT_VEC;
        #1;
        chk("ab cmd_ready", cmd_ready, 1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        #1;
        chk("ab load_act", {wrEn_act_array, wrData_act}, {1'b1, ACT_VEC});
        @(posedge clk); #2;
        scale_valid = 1'b1; scale_data = 4'h9;
        #1;
        chk("ab q write", {wrEn_queue, wrData_queue}, {1'b1, 4'h9});
        @(posedge clk); #2;
        abort = 1'b1; scale_data = 4'h6;
        #1;
        chk("ab q masked", {wrEn_queue, scale_ready, wrData_queue}, 0);
        @(posedge clk); #2;
        abort = 1'b0; scale_valid = 1'b0;
        #1;
        chk("ab idle", {busy, cmd_ready, done}, 3'b010);
        @(posedge clk); #3;
        chk("ab no done", done, 0);

        // zero passes: done pulse, no datapath activity
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_num_passes = 8'd0; scale_valid = 1'b1; wt_valid = 1'b1;
        #1;
        chk("z cmd_ready", cmd_ready, 1);
        n_act = 0; n_done = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #2;
            cmd_valid = 1'b0;
            #1;
            if (k == 1) chk("z done pulse", done, 1);
            if (done) n_done++;
            if (wrEn_act_array || wrEn_queue || wt_ready || flop_1_en_in || SRAM_flop_en_in || busy)
                n_act++;
        end
        chk("z done count", n_done, 1);
        chk("z strobes", n_act, 0);
        quiet_inputs();

        // asynchronous reset on the third stream beat
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #2;
            cmd_valid = (k == 0); cmd_num_passes = 8'd1;
            scale_valid = 1'b1; wt_valid = 1'b1;
            if (k == 8) reset = 1'b0;
            #1;
            if (k == 7) chk("mr streaming", flop_1_en_in, 1);
        end
        chk("mr enables", {SRAM_flop_en_in, flop_1_en_in, flop_3_en_in, queue_en_in}, 0);
        chk("mr idle", {cmd_ready, busy, wt_ready}, 3'b100);
        quiet_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_job(8'd1, 1'b0, 0);
        chk("mr job finished", done_k >= 0, 1);
        chk("mr job latency", first_res - 1, 17);
        chk("mr job result", res_err, 0);
        chk("mr job counts", {8'(n_act), 8'(n_q), 8'(n_wt), 8'(n_res), 8'(n_done)},
            {8'd1, 8'd4, 8'd8, 8'd1, 8'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
